// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle, followed by a
// single sign-correction cycle. Latency from the accepting edge to the
// done cycle is 34 cycles (the cycle right after the accepting edge is
// cycle 1).
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed
// overflow are answered directly from IDLE (done in cycle 1, busy never
// set). Without it those cases take the full path and FIX forces the
// architected values; results are identical either way.
`timescale 1ns/1ps
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  divsel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_REM  = 3'b011;
  localparam logic [2:0] OP_REMU = 3'b100;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q;      // partial remainder
  logic [31:0] quo_q;      // dividend bits shifting out, quotient bits shifting in
  logic [31:0] dvs_q;      // divisor magnitude
  logic [2:0]  op_q;
  logic        qneg_q;
  logic        rneg_q;
  logic        div0_q;
  logic        ovf_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  // Input decode: operation class, operand magnitudes and special cases.
  logic        op_valid, op_signed, op_rem, a_neg, b_neg, in_div0, in_ovf;
  logic [31:0] a_mag, b_mag;
  always_comb begin
    op_valid  = (divsel >= OP_DIV) && (divsel <= OP_REMU);
    op_signed = (divsel == OP_DIV) || (divsel == OP_REM);
    op_rem    = (divsel == OP_REM) || (divsel == OP_REMU);
    a_neg     = op_signed & dividend[31];
    b_neg     = op_signed & divisor[31];
    a_mag     = a_neg ? (32'd0 - dividend) : dividend;
    b_mag     = b_neg ? (32'd0 - divisor) : divisor;
    in_div0   = (divisor == 32'd0);
    in_ovf    = op_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // The borrow out of the 33-bit subtraction decides the quotient bit.
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        fits;
  logic        diff_unused;
  logic [31:0] rem_d, quo_d;
  always_comb begin
    shifted     = {rem_q, quo_q[31]};
    diff        = {1'b0, shifted} - {2'b00, dvs_q};
    fits        = ~diff[33];
    diff_unused = diff[32];   // always 0 when fits: remainder stays below divisor
    rem_d       = fits ? diff[31:0] : shifted[31:0];
    quo_d       = {quo_q[30:0], fits};
  end

  // Sign correction and forced values for the architected corner cases.
  logic        fix_rem;
  logic [31:0] fix_mag, fix_d;
  always_comb begin
    fix_rem = (op_q == OP_REM) || (op_q == OP_REMU);
    fix_mag = fix_rem ? rem_q : quo_q;
    fix_d   = (fix_rem ? rneg_q : qneg_q) ? (32'd0 - fix_mag) : fix_mag;
    if (div0_q && !fix_rem)
      fix_d = 32'hFFFF_FFFF;
    if (ovf_q)
      fix_d = fix_rem ? 32'd0 : 32'h8000_0000;
  end

`ifdef DIV_EARLY_OUT_EN
  // Immediate answer for the corner cases handled straight from IDLE.
  logic [31:0] early_res;
  always_comb begin
    if (in_div0)
      early_res = op_rem ? dividend : 32'hFFFF_FFFF;
    else
      early_res = op_rem ? 32'd0 : 32'h8000_0000;
  end
`endif

  // Control FSM with registered busy/done/result; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && op_valid && !flush) begin
            op_q   <= divsel;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            div0_q <= in_div0;
            ovf_q  <= in_ovf;
            rem_q  <= '0;
            quo_q  <= a_mag;
            dvs_q  <= b_mag;
            cnt_q  <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (in_div0 || in_ovf) begin
              result_q <= early_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
`else
            busy_q  <= 1'b1;
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31)
              state_q <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (flush) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
